instr_fetch: RTL
================

# instr_fetch

Instruction fetch unit for the RV32I core: the consuming end of the program-counter path. It owns the fetch address, issues word reads to instruction memory over a req/ack handshake, and buffers returned words with their PCs in a small queue for decode. A redirect from execute (branch/jump) replaces the fetch address and flushes the queue.

## Interface
- RESET_ADDR, 32'h00000000, fetch address loaded by reset
- DEPTH, 2, instruction queue entries (power of two, >= 2)
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- redirect  input  1  one-cycle pulse: load new fetch address, flush queue
- redirect_addr  input  32  target address, valid with redirect
- imem_req  output  1  read request, registered
- imem_addr  output  32  word address, stable while imem_req high, registered
- imem_ack  input  1  transfer completes on an edge where imem_req && imem_ack
- imem_rdata  input  32  instruction word, valid in ack cycle
- out_valid  output  1  queue head valid
- out_ready  input  1  decode accepts head when out_valid && out_ready
- out_instr  output  32  head instruction
- out_pc  output  32  head instruction address
- misalign_err  output  1  sticky: misaligned redirect received

## Operation
- Reset values: imem_req 0, imem_addr RESET_ADDR, fetch_addr RESET_ADDR, queue empty, out_valid 0, out_instr 0, out_pc 0, misalign_err 0, state IDLE.
- States:
  - IDLE: no request outstanding. Issue (imem_req 1, imem_addr = fetch_addr) when the queue is not full and misalign_err is 0.
  - WAIT: request outstanding. On ack: push {fetch_addr, imem_rdata}, fetch_addr += 4 (mod 2^32). If the post-edge count (push and pop applied) < DEPTH, keep imem_req high with the new address (back-to-back); otherwise go to IDLE.
  - DROP: request outstanding but stale. imem_req/imem_addr held unchanged until ack. On ack, discard data and go to IDLE.
- A request is never withdrawn before ack; imem_addr never changes while imem_req high.
- Queue: FIFO with pop on out_valid && out_ready. Push and pop in the same cycle leave count unchanged. Full occupancy never overflows, because issue requires a free slot.
- Redirect (priority over everything except reset):
  - queue flushed (count 0) and fetch_addr <= redirect_addr.
  - In WAIT without same-cycle ack, go to DROP.
  - In WAIT with same-cycle ack, discard data, then issue redirect_addr next cycle (state WAIT, if aligned).
  - In IDLE, issue redirect_addr next cycle.
  - In DROP, stay in DROP with fetch_addr updated.
  - Any output handshake in the redirect cycle has no effect beyond the flush; decode discards it.
- Misalignment: redirect with redirect_addr[1:0] != 0 sets misalign_err next cycle. No further requests issue; an in-flight request completes as DROP. Cleared only by reset.
- Reset mid-handshake: imem_req drops next cycle regardless of pending ack. Memory shares the same reset.

## Timing
- First request: imem_req high in the first cycle after reset deasserts, imem_addr = RESET_ADDR.
- Ack at edge E gives out_valid high after E, with out_pc/out_instr of that word. Fetch-to-decode latency is 1 cycle after ack.
- Zero-wait memory (ack tied high) with out_ready high sustains one instruction per cycle.
- After a redirect at edge R, out_valid is low after R. With no stale request, the new request is asserted after R and its data is visible after its ack edge.
- After a redirect in WAIT without ack, the stale ack is consumed first. The new request asserts in the cycle after the stale ack.

## Test plan
- Reset release with ack tied 1 and out_ready 1 -> imem_addr 0x0, 0x4, 0x8… on consecutive cycles. out_pc follows one cycle behind, and out_instr matches the memory image.
- out_ready held 0 with DEPTH 2 and ack tied 1 -> exactly 2 entries (pc 0x0, 0x4) queued, imem_req drops to 0. Raising out_ready yields 0x0 then 0x4, and fetching resumes at 0x8.
- Ack delayed 3 cycles -> imem_req and imem_addr 0x0 stable for all 3 cycles. out_valid rises the cycle after ack.
- Redirect to 0x100 while a request for 0x8 is outstanding -> queue empties next cycle and 0x8 data is never output. Request 0x100 is issued after the stale ack, and the first out_pc is 0x100.
- Redirect to 0xFFFFFFFC then continue -> out_pc 0xFFFFFFFC followed by 0x00000000 (wrap).
- Redirect to 0x102 -> misalign_err 1 next cycle and stays 1, with no further imem_req. Reset clears it and fetch restarts at RESET_ADDR.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: RV32I fetch unit -- owns the fetch PC, reads imem over req/ack, queues words+PCs for decode
//
// Ports
//   clk_i, reset_i            clock, synchronous active-high reset
//   redirect_i/_addr_i        one-cycle redirect pulse and target; flushes the queue
//   imem_req_o/_addr_o        registered word-read request, address held until ack
//   imem_ack_i/_rdata_i       transfer completes on an edge with req && ack
//   out_valid_o/_ready_i      queue head handshake towards decode
//   out_instr_o/_pc_o         head instruction word and its address (zero when empty)
//   misalign_err_o            sticky flag: a redirect target was not word aligned
module instr_fetch #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          DEPTH      = 2
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_instr_o,
  output logic [31:0] out_pc_o,
  output logic        misalign_err_o
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  // DROP marks a request whose data became stale through a redirect; its ack is swallowed.
  typedef enum logic [1:0] {IDLE, WAIT, DROP} state_e;
  state_e      state_q;
  logic        imem_req_q;
  logic        misalign_q;
  logic [31:0] imem_addr_q;
  logic [31:0] fetch_addr_q;
  logic [31:0] pc_q    [DEPTH];
  logic [31:0] instr_q [DEPTH];
  logic [AW-1:0] rd_q;
  logic [AW-1:0] wr_q;
  logic [AW:0] cnt_q;
  logic [AW:0] cnt_d;
  logic        ack;
  logic        pop;
  logic        push;
  logic        bad;
  logic        halt;
  logic [31:0] next_addr;
  always_comb begin
    ack       = imem_req_q & imem_ack_i;
    pop       = (cnt_q != '0) & out_ready_i;
    push      = ack & (state_q == WAIT) & ~redirect_i;
    cnt_d     = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    bad       = redirect_addr_i[1:0] != 2'b00;
    halt      = misalign_q | bad;
    next_addr = fetch_addr_q + 32'd4;
  end
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      pc_q[wr_q]    <= fetch_addr_q;
      instr_q[wr_q] <= imem_rdata_i;
    end
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      imem_req_q   <= 1'b0;
      imem_addr_q  <= RESET_ADDR;
      fetch_addr_q <= RESET_ADDR;
      misalign_q   <= 1'b0;
      cnt_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
    end else if (redirect_i) begin
      cnt_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      fetch_addr_q <= redirect_addr_i;
      misalign_q   <= halt;
      case (state_q)
        WAIT: begin
          if (!ack) begin
            state_q <= DROP;
          end else if (!halt) begin
            imem_addr_q <= redirect_addr_i;
          end else begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
          end
        end
        DROP: begin
          if (ack) begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
          end
        end
        default: begin
          if (!halt) begin
            state_q     <= WAIT;
            imem_req_q  <= 1'b1;
            imem_addr_q <= redirect_addr_i;
          end
        end
      endcase
    end else begin
      cnt_q <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop) rd_q <= rd_q + AW'(1);
      case (state_q)
        WAIT: begin
          if (ack) begin
            fetch_addr_q <= next_addr;
            // Keep the request up back-to-back only while a slot remains after this edge.
            if (cnt_d < FULL) begin
              imem_addr_q <= next_addr;
            end else begin
              state_q    <= IDLE;
              imem_req_q <= 1'b0;
            end
          end
        end
        DROP: begin
          if (ack) begin
            state_q    <= IDLE;
            imem_req_q <= 1'b0;
          end
        end
        default: begin
          if (cnt_q < FULL && !misalign_q) begin
            state_q     <= WAIT;
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_addr_q;
          end
        end
      endcase
    end
  end
  assign imem_req_o     = imem_req_q;
  assign imem_addr_o    = imem_addr_q;
  assign misalign_err_o = misalign_q;
  assign out_valid_o    = cnt_q != '0;
  assign out_instr_o    = out_valid_o ? instr_q[rd_q] : '0;
  assign out_pc_o       = out_valid_o ? pc_q[rd_q] : '0;
endmodule
